// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - sequencing front end for the radix-2 Booth multiplier datapath
module mul_ctrl #(
  parameter int WIDTH = 64,
  parameter int STEPS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_multiplier,
  input  logic [WIDTH-1:0]     in_multiplicand,
  output logic [1:0]           dp_state,
  output logic [6:0]           dp_counter,
  output logic [WIDTH-1:0]     dp_multiplier,
  output logic [WIDTH-1:0]     dp_multiplicand,
  input  logic                 dp_op_done,
  input  logic [2*WIDTH-1:0]   dp_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Encodings the datapath understands; LOAD reuses the IDLE code so the
  // datapath seeds its accumulator from operands already held stable.
  localparam logic [1:0] DP_IDLE = 2'b00;
  localparam logic [1:0] DP_EXEC = 2'b01;
  localparam logic [1:0] DP_DONE = 2'b10;
  localparam logic [6:0] STEPS_C = 7'(STEPS);

  state_t             state, state_nx;
  logic [1:0]         dp_state_nx;
  logic [6:0]         dp_counter_nx;
  logic [WIDTH-1:0]   dp_multiplier_nx, dp_multiplicand_nx;
  logic               out_valid_nx;
  logic [2*WIDTH-1:0] out_result_nx;
  logic               err_nx;

  // Handshake decodes come straight from the FSM state.
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // State register and all registered outputs; reset restores idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      dp_state        <= DP_IDLE;
      dp_counter      <= 7'd0;
      dp_multiplier   <= '0;
      dp_multiplicand <= '0;
      out_valid       <= 1'b0;
      out_result      <= '0;
      err             <= 1'b0;
    end else begin
      state           <= state_nx;
      dp_state        <= dp_state_nx;
      dp_counter      <= dp_counter_nx;
      dp_multiplier   <= dp_multiplier_nx;
      dp_multiplicand <= dp_multiplicand_nx;
      out_valid       <= out_valid_nx;
      out_result      <= out_result_nx;
      err             <= err_nx;
    end
  end

  // Next-state and next-output decode; op_clear overrides every handshake.
  always_comb begin
    state_nx           = state;
    dp_state_nx        = dp_state;
    dp_counter_nx      = dp_counter;
    dp_multiplier_nx   = dp_multiplier;
    dp_multiplicand_nx = dp_multiplicand;
    out_valid_nx       = out_valid;
    out_result_nx      = out_result;
    err_nx             = err;

    if (op_clear) begin
      state_nx      = S_IDLE;
      dp_state_nx   = DP_IDLE;
      dp_counter_nx = 7'd0;
      out_valid_nx  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dp_multiplier_nx   = in_multiplier;
            dp_multiplicand_nx = in_multiplicand;
            dp_counter_nx      = 7'd0;
            dp_state_nx        = DP_IDLE;
            state_nx           = S_LOAD;
          end
        end
        S_LOAD: begin
          dp_counter_nx = 7'd0;
          dp_state_nx   = DP_EXEC;
          state_nx      = S_EXEC;
        end
        S_EXEC: begin
          if (dp_counter < STEPS_C) begin
            dp_counter_nx = dp_counter + 7'd1;
          end else begin
            // Final iteration: product is ready; a missing done flag is a
            // protocol error but the result is still handed downstream.
            out_result_nx = dp_result;
            out_valid_nx  = 1'b1;
            dp_state_nx   = DP_DONE;
            state_nx      = S_DONE;
            if (!dp_op_done) begin
              err_nx = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_nx  = 1'b0;
            dp_counter_nx = 7'd0;
            dp_state_nx   = DP_IDLE;
            state_nx      = S_IDLE;
          end
        end
        default: begin
          state_nx    = S_IDLE;
          dp_state_nx = DP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - scoreboard testbench for mul_ctrl
module tb_mul_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_clear;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_multiplier;
  logic [63:0]  in_multiplicand;
  logic [1:0]   dp_state;
  logic [6:0]   dp_counter;
  logic [63:0]  dp_multiplier;
  logic [63:0]  dp_multiplicand;
  logic         dp_op_done;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
  logic         busy;
  logic         err;

  logic         withhold_done;
  logic signed [127:0] ext_a, ext_b;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  mul_ctrl #(.WIDTH(64), .STEPS(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .op_clear        (op_clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_multiplier   (in_multiplier),
    .in_multiplicand (in_multiplicand),
    .dp_state        (dp_state),
    .dp_counter      (dp_counter),
    .dp_multiplier   (dp_multiplier),
    .dp_multiplicand (dp_multiplicand),
    .dp_op_done      (dp_op_done),
    .dp_result       (dp_result),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .busy            (busy),
    .err             (err)
  );

  // Datapath stub: full signed product, done flag at the last iteration.
  assign ext_a      = {{64{dp_multiplier[63]}}, dp_multiplier};
  assign ext_b      = {{64{dp_multiplicand[63]}}, dp_multiplicand};
  assign dp_result  = ext_a * ext_b;
  assign dp_op_done = (dp_counter == 7'd64) && !withhold_done;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is compared with the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !op_clear) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected actual=%h expected=none", out_result);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (out_result !== e) begin
          failures++;
          $display("FAIL result actual=%h expected=%h", out_result, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] a, input logic [63:0] b);
    in_multiplier   = a;
    in_multiplicand = b;
    in_valid        = 1'b1;
    step();
    in_valid        = 1'b0;
  endtask

  // Cycles from accept edge until out_valid is seen; bounded.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
      if (n == 1) begin
        check({name, "_load_state"}, 128'(dp_state), 128'(2'b01));
        check({name, "_load_cnt"}, 128'(dp_counter), 128'd0);
      end
      if (dp_counter > 7'd64) check({name, "_cnt_over"}, 128'(dp_counter), 128'd64);
    end
    check({name, "_latency"}, 128'(n), 128'd66);
  endtask

  task automatic run_to_count(input logic [6:0] target);
    int n;
    n = 0;
    while (dp_counter != target && n < 200) begin
      step();
      n++;
    end
    check("reach_count", 128'(dp_counter), 128'(target));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_state"}, 128'(dp_state), 128'd0);
    check({name, "_cnt"}, 128'(dp_counter), 128'd0);
    check({name, "_mplier"}, 128'(dp_multiplier), 128'd0);
    check({name, "_mcand"}, 128'(dp_multiplicand), 128'd0);
    check({name, "_result"}, out_result, 128'd0);
    check({name, "_flags"}, 128'({out_valid, busy, err, in_ready}), 128'(4'b0001));
  endtask

  initial begin
    reset = 1'b1; op_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_multiplier = '0; in_multiplicand = '0; withhold_done = 1'b0;
    step(); step();
    reset = 1'b0;
    check_reset_values("reset");
    step();
    check("reset_in_ready", 128'(in_ready), 128'd1);

    // Basic multiply: 3 x -5
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    accept(64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    check("basic_busy", 128'(busy), 128'd1);
    wait_valid("basic");
    check("basic_done_state", 128'(dp_state), 128'(2'b10));
    step();
    check("basic_ready_after", 128'({in_ready, out_valid, dp_counter}), 128'({1'b1, 1'b0, 7'd0}));

    // Backpressure with an ignored second request
    out_ready = 1'b0;
    exp_q.push_back(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE);
    accept(64'h7FFF_FFFF_FFFF_FFFF, 64'd2);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_multiplier = 64'd5; in_multiplicand = 64'd7; in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      check("bp_hold_result", out_result, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE);
      check("bp_hold_state", 128'({dp_state, out_valid, in_ready}), 128'({2'b10, 1'b1, 1'b0}));
    end
    check("bp_operands", 128'({dp_multiplier, dp_multiplicand}),
          {64'h7FFF_FFFF_FFFF_FFFF, 64'd2});
    out_ready = 1'b1;
    step();
    check("bp_release", 128'({out_valid, in_ready}), 128'(2'b01));

    // Abort at counter 20, then a normal op
    accept(64'd1, 64'd1);
    run_to_count(7'd20);
    op_clear = 1'b1;
    step();
    op_clear = 1'b0;
    check("abort_state", 128'({dp_state, dp_counter, out_valid, busy, in_ready}),
          128'({2'b00, 7'd0, 1'b0, 1'b0, 1'b1}));
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1);
    accept(64'hFFFF_FFFF_FFFF_FFF9, 64'd9);
    wait_valid("after_abort");
    step();

    // op_clear with in_valid in IDLE: no accept
    op_clear = 1'b1;
    accept(64'd11, 64'd13);
    op_clear = 1'b0;
    check("clr_idle_flags", 128'({busy, in_ready, dp_state}), 128'({1'b0, 1'b1, 2'b00}));
    check("clr_idle_operand", 128'(dp_multiplier), 128'(64'hFFFF_FFFF_FFFF_FFF9));
    step();
    check("clr_idle_stay", 128'(busy), 128'd0);

    // op_clear with out_ready in DONE: result dropped
    out_ready = 1'b0;
    accept(64'd2, 64'd3);
    wait_valid("clr_done");
    op_clear = 1'b1; out_ready = 1'b1;
    step();
    op_clear = 1'b0;
    check("clr_done_flags", 128'({out_valid, busy, dp_state}), 128'({1'b0, 1'b0, 2'b00}));
    check("clr_done_keep", out_result, 128'd6);

    // Error flag: done withheld, then sticky across a clean op
    withhold_done = 1'b1;
    exp_q.push_back(128'd16);
    accept(64'd4, 64'd4);
    wait_valid("err");
    check("err_set", 128'(err), 128'd1);
    step();
    withhold_done = 1'b0;
    exp_q.push_back(128'd1);
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid("err2");
    step();
    check("err_sticky", 128'(err), 128'd1);

    // Reset in the middle of EXEC
    accept(64'd5, 64'd5);
    run_to_count(7'd40);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values("midreset");

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
